// File: rtl/uart_imem_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
//   - Default UART timing and instruction-memory address width.
//   - Loader FSM and receiver state encodings, kept as plain constants so
//     older code that compares raw state values keeps working.
//   - push_byte(): little-endian word assembly helper.
package uart_imem_loader_pkg;

  localparam int LOADER_CLKS_PER_BIT = 868;  // 100 MHz board clock / 115200 baud
  localparam int IMEM_ADDR_WIDTH     = 14;

  // Loader framing FSM encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CSUM   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  // UART receiver encodings
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Shift a new byte in at the top. After four calls, the first byte that
  // was shifted in ends up in bits [7:0].
  function automatic logic [31:0] push_byte(input logic [31:0] word, input logic [7:0] b);
    return {b, word[31:8]};
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The serial line idles high and data is sent LSB first.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   rx        - raw serial input, passed through a two-flop synchroniser
//   rx_valid  - one-cycle pulse when a byte with a good stop bit arrives
//   rx_byte   - the received byte; it holds its value between bytes
//   rx_ferr   - one-cycle pulse when the stop bit is sampled low
// Parameter CLKS_PER_BIT (at least 4) sets the bit period in clk cycles.
module uart_rx
  import uart_imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = LOADER_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          prev_r;
  logic [1:0]    rx_state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          rx_valid_r;
  logic [7:0]    rx_byte_r;
  logic          rx_ferr_r;

  // Synchroniser, bit timer and shifter. After a falling edge the receiver
  // waits half a bit and samples the start bit again; if the line is high,
  // the edge was a glitch. After that, each sample falls at a bit centre.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r    <= 1'b1;
      sync2_r    <= 1'b1;
      prev_r     <= 1'b1;
      rx_state_r <= RX_IDLE;
      cnt_r      <= '0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      rx_valid_r <= 1'b0;
      rx_byte_r  <= 8'h00;
      rx_ferr_r  <= 1'b0;
    end else begin
      sync1_r    <= rx;
      sync2_r    <= sync1_r;
      prev_r     <= sync2_r;
      rx_valid_r <= 1'b0;
      rx_ferr_r  <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          cnt_r     <= '0;
          bit_idx_r <= 3'd0;
          if (prev_r && !sync2_r) begin
            rx_state_r <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r      <= '0;
            rx_state_r <= sync2_r ? RX_IDLE : RX_DATA;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r     <= '0;
            shift_r   <= {sync2_r, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              rx_state_r <= RX_STOP;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r      <= '0;
            rx_state_r <= RX_IDLE;
            if (sync2_r) begin
              rx_valid_r <= 1'b1;
              rx_byte_r  <= shift_r;
            end else begin
              rx_ferr_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  assign rx_valid = rx_valid_r;
  assign rx_byte  = rx_byte_r;
  assign rx_ferr  = rx_ferr_r;

endmodule

// File: rtl/uart_imem_loader.sv
// Serial bootloader. It receives a program image over UART and writes it into
// instruction memory one 32-bit word at a time, and it keeps the CPU on hold
// while it loads.
//
// Image format: N[7:0], N[15:8], then 4*N payload bytes. Each word is sent
// little-endian.
//
// Build option LOADER_CHECKSUM_EN: the image is followed by one more byte,
// which must equal the XOR of the two length bytes and all payload bytes.
// On a match the loader goes to DONE; on a mismatch it goes to ERROR. Any
// words already written stay in memory.
//
// Ports:
//   clk, rst   - board clock and asynchronous active-high reset
//   load_en    - level; high arms the loader, low aborts and returns to idle
//   uart_rx    - serial input (8N1, LSB first)
//   imem_we    - one-cycle write strobe
//   imem_addr  - word address; it holds its value between writes
//   imem_wdata - write data; it holds its value between writes
//   cpu_hold   - high while armed and not in DONE
//   done, err  - image complete / framing or checksum error
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = LOADER_CLKS_PER_BIT,
  parameter int ADDR_WIDTH   = IMEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic                  uart_rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_AFTER_PAYLOAD = ST_CSUM;
`else
  localparam logic [2:0] ST_AFTER_PAYLOAD = ST_DONE;
`endif

  logic                  rx_valid_s;
  logic [7:0]            rx_byte_s;
  logic                  rx_ferr_s;

  logic [2:0]            state_r;
  logic [2:0]            state_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [1:0]            byte_idx_r;
  logic [31:0]           word_r;
  logic [7:0]            len_lo_r;
  logic [15:0]           len_r;
  logic [15:0]           words_r;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_r;
`endif

  logic                  we_r;
  logic [ADDR_WIDTH-1:0] imem_addr_r;
  logic [31:0]           imem_wdata_r;
  logic                  hold_r;
  logic                  done_r;
  logic                  err_r;

  logic                  word_done_s;
  logic                  last_word_s;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (uart_rx),
    .rx_valid (rx_valid_s),
    .rx_byte  (rx_byte_s),
    .rx_ferr  (rx_ferr_s)
  );

  // The fourth byte of a word has arrived, and the load is still armed.
  assign word_done_s = load_en && (state_r == ST_DATA) && rx_valid_s && (byte_idx_r == 2'd3);
  // The word now being completed is word N. A separate word count is kept
  // because the address counter wraps.
  assign last_word_s = ((words_r + 16'd1) == len_r);

  // Next-state logic. Dropping load_en overrides everything else.
  always_comb begin
    state_nxt_s = state_r;
    if (!load_en) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_LEN_LO;
        ST_LEN_LO: begin
          if (rx_ferr_s) begin
            state_nxt_s = ST_ERROR;
          end else if (rx_valid_s) begin
            state_nxt_s = ST_LEN_HI;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_LEN_HI: begin
          if (rx_ferr_s) begin
            state_nxt_s = ST_ERROR;
          end else if (rx_valid_s) begin
            state_nxt_s = ({rx_byte_s, len_lo_r} == 16'd0) ? ST_AFTER_PAYLOAD : ST_DATA;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_DATA: begin
          if (rx_ferr_s) begin
            state_nxt_s = ST_ERROR;
          end else if (word_done_s && last_word_s) begin
            state_nxt_s = ST_AFTER_PAYLOAD;
          end else begin
            state_nxt_s = state_r;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (rx_ferr_s) begin
            state_nxt_s = ST_ERROR;
          end else if (rx_valid_s) begin
            state_nxt_s = (rx_byte_s == csum_r) ? ST_DONE : ST_ERROR;
          end else begin
            state_nxt_s = state_r;
          end
        end
`endif
        ST_DONE:  state_nxt_s = ST_DONE;
        ST_ERROR: state_nxt_s = ST_ERROR;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Holds the state register, the length/word/address datapath and the
  // registered memory-port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      addr_r       <= '0;
      byte_idx_r   <= 2'd0;
      word_r       <= 32'h0000_0000;
      len_lo_r     <= 8'h00;
      len_r        <= 16'h0000;
      words_r      <= 16'h0000;
`ifdef LOADER_CHECKSUM_EN
      csum_r       <= 8'h00;
`endif
      we_r         <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= 32'h0000_0000;
      hold_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      we_r    <= 1'b0;
      hold_r  <= load_en && (state_nxt_s != ST_DONE);
      done_r  <= (state_nxt_s == ST_DONE);
      err_r   <= (state_nxt_s == ST_ERROR);
      case (state_r)
        ST_IDLE: begin
          addr_r     <= '0;
          byte_idx_r <= 2'd0;
          words_r    <= 16'h0000;
          word_r     <= 32'h0000_0000;
        end
        ST_LEN_LO: begin
          if (rx_valid_s) begin
            len_lo_r <= rx_byte_s;
`ifdef LOADER_CHECKSUM_EN
            csum_r   <= rx_byte_s;
`endif
          end
        end
        ST_LEN_HI: begin
          if (rx_valid_s) begin
            len_r  <= {rx_byte_s, len_lo_r};
`ifdef LOADER_CHECKSUM_EN
            csum_r <= csum_r ^ rx_byte_s;
`endif
          end
        end
        ST_DATA: begin
          if (rx_valid_s) begin
            word_r     <= push_byte(word_r, rx_byte_s);
            byte_idx_r <= byte_idx_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_r     <= csum_r ^ rx_byte_s;
`endif
          end
          if (word_done_s) begin
            we_r         <= 1'b1;
            imem_addr_r  <= addr_r;
            imem_wdata_r <= push_byte(word_r, rx_byte_s);
            addr_r       <= addr_r + ADDR_WIDTH'(1);
            words_r      <= words_r + 16'd1;
          end
        end
        default: begin
          // CSUM, DONE and ERROR only change state.
        end
      endcase
    end
  end

  assign imem_we    = we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_hold   = hold_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader (ADDR_WIDTH = 2 so address wrap is
// reachable, short bit period). Expected memory writes come from the image
// bytes themselves; a monitor checks every write strobe and the hold behaviour
// of the write port on every cycle.
module tb_uart_imem_loader;

  localparam int CPB = 16;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic          uart_rx;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .uart_rx    (uart_rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           exp_e;
  int            checks = 0;
  int            passes = 0;
  logic          prev_we;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_data;
  logic [7:0]    img[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Write-port monitor: every strobe must match the next expected write, and
  // the port must hold its last value while the strobe is low.
  always @(negedge clk) begin
    if (rst) begin
      prev_we   = 1'b0;
      last_addr = '0;
      last_data = 32'h0;
    end else begin
      if (imem_we) begin
        check("we_single_cycle", 32'(prev_we), 32'd0);
        check("write_was_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("wr_addr", 32'(imem_addr), 32'(exp_e.addr));
          check("wr_data", imem_wdata, exp_e.data);
        end
        last_addr = imem_addr;
        last_data = imem_wdata;
      end else begin
        check("addr_hold", 32'(imem_addr), 32'(last_addr));
        check("wdata_hold", imem_wdata, last_data);
      end
      prev_we = imem_we;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CPB);
    end
    uart_rx = stop_bit;
    idle(CPB);
    uart_rx = 1'b1;
    idle($urandom_range(1, CPB));
  endtask

  // Send the first cnt bytes of the image queue.
  task automatic send_seq(input logic [7:0] q[$], input int cnt);
    for (int i = 0; i < cnt; i++) send_byte(q[i], 1'b1);
  endtask

  function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    return x;
  endfunction

  // Model: every complete group of 4 payload bytes becomes one little-endian
  // word at address (word index mod 2^AW).
  task automatic expect_words(input logic [7:0] q[$], input int payload_bytes);
    wr_t e;
    for (int w = 0; w < payload_bytes / 4; w++) begin
      e.addr = AW'(w % (1 << AW));
      e.data = {q[2+4*w+3], q[2+4*w+2], q[2+4*w+1], q[2+4*w]};
      exp_q.push_back(e);
    end
  endtask

  task automatic push_lit(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = AW'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_trailer(input logic [7:0] q[$]);
`ifdef LOADER_CHECKSUM_EN
    send_byte(xor_of(q), 1'b1);
`else
    send_byte(8'h5A, 1'b1);  // ignored after the payload
`endif
  endtask

  task automatic wait_status(input string name, input logic want_done, input logic want_err,
                             input int budget);
    int n = 0;
    while (!(done || err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 32'(done), 32'(want_done));
    check({name, "_err"}, 32'(err), 32'(want_err));
  endtask

  task automatic arm();
    load_en = 1'b1;
    idle(4);
  endtask

  task automatic disarm(input string name);
    load_en = 1'b0;
    idle(3);
    check({name, "_idle_done"}, 32'(done), 32'd0);
    check({name, "_idle_err"}, 32'(err), 32'd0);
    check({name, "_idle_hold"}, 32'(cpu_hold), 32'd0);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    idle(4);
  endtask

  initial begin
    rst     = 1'b1;
    load_en = 1'b0;
    uart_rx = 1'b1;
    idle(5);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    idle(5);

    // Normal two-word load
    arm();
    check("normal_hold", 32'(cpu_hold), 32'd1);
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    push_lit(0, 32'h00A0_0513);
    push_lit(1, 32'h0010_0593);
`ifdef LOADER_CHECKSUM_EN
    send_seq(img, img.size());
    send_trailer(img);
    wait_status("normal", 1'b1, 1'b0, 4 * CPB);
`else
    send_seq(img, img.size());
    wait_status("normal", 1'b1, 1'b0, 4 * CPB);
    send_trailer(img);
    check("normal_extra_done", 32'(done), 32'd1);
`endif
    check("normal_hold_released", 32'(cpu_hold), 32'd0);
    disarm("normal");

    // Empty image
    arm();
    img = '{8'h00, 8'h00};
    send_seq(img, 2);
`ifdef LOADER_CHECKSUM_EN
    check("empty_wait_csum", 32'(done), 32'd0);
    send_byte(8'h00, 1'b1);
`endif
    wait_status("empty", 1'b1, 1'b0, 2 * CPB);
    disarm("empty");

    // Framing error in the first payload byte
    arm();
    img = '{8'h01, 8'h00};
    send_seq(img, 2);
    send_byte(8'h37, 1'b0);
    wait_status("ferr", 1'b0, 1'b1, 2 * CPB);
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_seq(img, 4);
    check("ferr_sticky", 32'(err), 32'd1);
    disarm("ferr");

    // Abort mid-word, then a clean one-word image
    arm();
    img = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send_seq(img, 4);
    disarm("abort");
    arm();
    img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    push_lit(0, 32'h4433_2211);
    send_seq(img, img.size());
`ifdef LOADER_CHECKSUM_EN
    send_trailer(img);
`endif
    wait_status("rearm", 1'b1, 1'b0, 4 * CPB);
    disarm("rearm");

    // Short glitch must not produce a byte
    arm();
    uart_rx = 1'b0;
    idle(5);
    uart_rx = 1'b1;
    idle(3 * CPB);
    img = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    push_lit(0, 32'h1234_5678);
    send_seq(img, img.size());
`ifdef LOADER_CHECKSUM_EN
    send_trailer(img);
`endif
    wait_status("glitch", 1'b1, 1'b0, 4 * CPB);
    disarm("glitch");

    // Five words wrap a 2-bit address counter
    arm();
    img = '{8'h05, 8'h00};
    for (int j = 0; j < 20; j++) img.push_back(8'($urandom_range(0, 255)));
    for (int w = 0; w < 5; w++) begin
      push_lit((w == 4) ? 0 : w, {img[2+4*w+3], img[2+4*w+2], img[2+4*w+1], img[2+4*w]});
    end
    send_seq(img, img.size());
`ifdef LOADER_CHECKSUM_EN
    send_trailer(img);
`endif
    wait_status("wrap", 1'b1, 1'b0, 4 * CPB);
    disarm("wrap");

`ifdef LOADER_CHECKSUM_EN
    // Checksum good, then bad
    arm();
    img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    push_lit(0, 32'hDEAD_BEEF);
    send_seq(img, img.size());
    send_byte(8'h23, 1'b1);
    wait_status("csum_good", 1'b1, 1'b0, 4 * CPB);
    disarm("csum_good");
    arm();
    push_lit(0, 32'hDEAD_BEEF);
    send_seq(img, img.size());
    send_byte(8'h24, 1'b1);
    wait_status("csum_bad", 1'b0, 1'b1, 4 * CPB);
    disarm("csum_bad");
`endif

    // Randomised images: full load, abort, or framing error
    for (int it = 0; it < 8; it++) begin
      int n;
      int mode;
      int k;
      n    = $urandom_range(1, 4);
      mode = $urandom_range(0, 2);
      img.delete();
      img.push_back(8'(n));
      img.push_back(8'h00);
      for (int j = 0; j < 4 * n; j++) img.push_back(8'($urandom_range(0, 255)));
      arm();
      if (mode == 0) begin
        expect_words(img, 4 * n);
        send_seq(img, img.size());
`ifdef LOADER_CHECKSUM_EN
        send_trailer(img);
`endif
        wait_status("rand_full", 1'b1, 1'b0, 4 * CPB);
      end else begin
        k = $urandom_range(0, 4 * n - 1);
        expect_words(img, k);
        send_seq(img, 2 + k);
        if (mode == 2) begin
          send_byte(8'($urandom_range(0, 255)), 1'b0);
          wait_status("rand_ferr", 1'b0, 1'b1, 4 * CPB);
        end else begin
          check("rand_abort_done", 32'(done), 32'd0);
        end
      end
      disarm("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
